tally_expander: RTL
===================

Name: tally_expander

Overview:
- Converts 6-bit-tally counts back into a bit-serial unary code: for count n, emits n '1' bits followed by one '0' terminator.
- A downstream run tallier recovers n by counting the 1s up to the terminator.
- Sits on the decode side of the Huffman accelerator, between count producers and the bit-serial code path.
- Valid/ready handshake on both sides, with a small input FIFO so producers can queue counts.

Parameters:
- CNT_W, 8, width of input count; matches the tallier output width.
- MAX_COUNT, 6, largest legal count, equal to the tallier input width. Larger counts are clamped to this value.
- FIFO_DEPTH, 2, number of queued input counts; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_count  in  CNT_W  count to expand.
- in_valid  in  1  in_count is valid.
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready.
- bit_out  out  1  serial code bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream accepts; a transfer occurs when bit_valid && bit_ready.
- bit_last  out  1  high with the terminator '0' bit of each code.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- err_clamp  out  1  one-cycle pulse when a popped count exceeded MAX_COUNT.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO is emptied, FSM goes to IDLE, remaining counter is cleared.
  - bit_valid=0, bit_out=0, bit_last=0, err_clamp=0, busy=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after rst deasserts.
  - Reset mid-operation discards the in-flight code and all queued counts; no partial code resumes afterwards.
- FIFO:
  - in_ready = !full. There is no pass-through: when full, in_ready=0 even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ONES, TERM. Remaining counter width is clog2(MAX_COUNT+1).
- Pop rule, used in IDLE and on the TERM handshake:
  - Pop the FIFO head and set remaining = min(count, MAX_COUNT).
  - err_clamp pulses in the following cycle if count > MAX_COUNT.
  - Go to ONES if remaining > 0, otherwise go to TERM.
- IDLE:
  - bit_valid=0.
  - If the FIFO is non-empty, apply the pop rule.
- ONES:
  - bit_valid=1, bit_out=1, bit_last=0.
  - On handshake: remaining decrements. If remaining was 1, go to TERM.
- TERM:
  - bit_valid=1, bit_out=0, bit_last=1.
  - On handshake: if the FIFO is non-empty, apply the pop rule (no bubble between codes); otherwise go to IDLE.
- Output hold: while bit_valid && !bit_ready, bit_out and bit_last stay stable and the FSM does not advance.
- Outputs bit_out, bit_valid and bit_last are registered from FSM state.
- Latency: a count accepted in cycle t with the FSM IDLE produces its first bit with bit_valid=1 in cycle t+2.
- Code length is min(n, MAX_COUNT)+1 bits. With continuous bit_ready, throughput is one bit per cycle across code boundaries.
- Count 0 emits a single '0' with bit_last=1.

Test Plan:
- Reset, then push 3 with bit_ready=1 held: bits 1,1,1,0 in cycles t+2..t+5; bit_last only on the 4th bit; busy returns to 0 afterwards; err_clamp stays 0.
- Push 0: exactly one bit, bit_out=0 with bit_last=1, at t+2; no '1' bits.
- Push 9 (MAX_COUNT=6): six '1' bits then a '0' with last; err_clamp pulses exactly once at the pop.
- Push 2 and 1 back-to-back with bit_ready=1: contiguous stream 1,1,0,1,0 with no idle cycle between codes; bit_last on the 3rd and 5th bits.
- bit_ready=0 for 5 cycles mid-code: bit_out and bit_last stay stable with bit_valid=1. Meanwhile push 4, 5, 6: in_ready falls after two accepts, and the third count is held by the producer until a pop occurs. All codes then emerge in order.
- Assert rst during the 2nd '1' bit of count 5 with one count queued: the next cycle shows bit_valid=0, busy=0 and an empty FIFO. A later push of 1 yields exactly 1,0.

Source files
------------

// File: rtl/tally_expander.sv
// tally_expander: expands queued counts into a bit-serial unary code (n ones, then a '0' terminator)
module tally_expander #(
  parameter int CNT_W      = 8,
  parameter int MAX_COUNT  = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             busy,
  output logic             err_clamp
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(MAX_COUNT + 1);

  typedef enum logic [1:0] {IDLE, ONES, TERM} state_t;

  logic [CNT_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [RW-1:0]    rem_q, rem_d, head_clamped;
  logic             bit_valid_q, bit_valid_d, bit_out_q, bit_out_d;
  logic             bit_last_q, bit_last_d, err_q, err_d;
  logic             push, pop, hs, full, empty, over;
  logic [CNT_W-1:0] head;

  assign full         = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign empty        = cnt_q == '0;
  assign in_ready     = !full && !rst;
  assign push         = in_valid && in_ready;
  assign hs           = bit_valid_q && bit_ready;
  assign head         = mem_q[rd_q];
  assign over         = head > CNT_W'(MAX_COUNT);
  assign head_clamped = over ? RW'(MAX_COUNT) : head[RW-1:0];
  assign pop          = !empty && (state_q == IDLE || (state_q == TERM && hs));
  assign busy         = state_q != IDLE || !empty;
  assign bit_valid    = bit_valid_q;
  assign bit_out      = bit_out_q;
  assign bit_last     = bit_last_q;
  assign err_clamp    = err_q;

  // Next-state: FIFO pointers, FSM walk through ones then terminator, back-to-back pop on terminator handshake
  always_comb begin
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d = state_q;
    rem_d   = rem_q;
    if (pop) begin
      rem_d   = head_clamped;
      state_d = head_clamped != '0 ? ONES : TERM;
    end else if (state_q == ONES && hs) begin
      rem_d   = rem_q - 1'b1;
      state_d = rem_q == RW'(1) ? TERM : ONES;
    end else if (state_q == TERM && hs) begin
      state_d = IDLE;
    end
    bit_valid_d = state_d != IDLE;
    bit_out_d   = state_d == ONES;
    bit_last_d  = state_d == TERM;
    err_d       = pop && over;
  end

  // Control and output registers; reset discards any in-flight code and queued counts
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      rem_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      bit_last_q  <= bit_last_d;
      err_q       <= err_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_count;
  end
endmodule
